// File: rtl/fp_norm_seq.sv
// fp_norm_seq
//   Multi-cycle normalizer between the float add/sub significand stage and
//   writeback. An operand is latched in IDLE, normalized one left shift per
//   clock in NORM (or a single right shift on carry), then presented in DONE
//   until the consumer takes it. Handles inf/NaN bypass, zero, flush-to-zero
//   and overflow-to-infinity.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     operand handshake (in_ready only in IDLE)
//   in_sign/exp/mant      raw result; mant[FRAC_W+1]=carry, mant[FRAC_W]=hidden
//   out_valid/out_ready   result handshake (out_valid only in DONE)
//   out_sign/exp/frac     normalized result, hidden bit dropped
//   out_ovf               overflowed to infinity
//   out_unf               nonzero significand flushed to zero
//   busy                  operand in flight (state != IDLE)
module fp_norm_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    logic [1:0]        state;
    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W+1:0] w_mant;

    // Result of this NORM cycle if it finishes; otherwise another left shift.
    logic              fin;
    logic [EXP_W-1:0]  res_exp;
    logic [FRAC_W-1:0] res_frac;
    logic              res_ovf;
    logic              res_unf;
    logic [EXP_W-1:0]  exp_inc;

    assign exp_inc = w_exp + EXP_ONE;

    always_comb begin
        fin      = 1'b1;
        res_exp  = '0;
        res_frac = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (w_exp == EXP_MAX) begin
            // inf/NaN: pass payload through untouched
            res_exp  = EXP_MAX;
            res_frac = w_mant[FRAC_W-1:0];
        end else if (w_mant == '0) begin
            // true zero, no flag
        end else if (w_exp == '0) begin
            res_unf = 1'b1;
        end else if (w_mant[FRAC_W+1]) begin
            // carry: one right shift, LSB dropped; frac comes from mant[FRAC_W:1]
            if (exp_inc == EXP_MAX) begin
                res_exp = EXP_MAX;
                res_ovf = 1'b1;
            end else begin
                res_exp  = exp_inc;
                res_frac = w_mant[FRAC_W:1];
            end
        end else if (w_mant[FRAC_W]) begin
            res_exp  = w_exp;
            res_frac = w_mant[FRAC_W-1:0];
        end else if (w_exp == EXP_ONE) begin
            // a further shift would take exp to 0: flush instead of going subnormal
            res_unf = 1'b1;
        end else begin
            fin = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            w_sign   <= 1'b0;
            w_exp    <= '0;
            w_mant   <= '0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_frac <= '0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_sign <= in_sign;
                        w_exp  <= in_exp;
                        w_mant <= in_mant;
                        state  <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (fin) begin
                        out_sign <= w_sign;
                        out_exp  <= res_exp;
                        out_frac <= res_frac;
                        out_ovf  <= res_ovf;
                        out_unf  <= res_unf;
                        state    <= S_DONE;
                    end else begin
                        // mant != 0 is checked first, so this terminates
                        // within FRAC_W shifts without a counter
                        w_mant <= w_mant << 1;
                        w_exp  <= w_exp - EXP_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fp_norm_seq.sv
module tb_fp_norm_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_ovf;
    logic        out_unf;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fp_norm_seq #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_ovf(out_ovf), .out_unf(out_unf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present one operand for a single edge; returns after that accept edge (+1).
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Compare a completed result against hand-computed values.
    task automatic check_res(input string nm, input int edges, input int exp_edges,
                             input logic s, input logic [7:0] e, input logic [22:0] f,
                             input logic ovf, input logic unf);
        checks++;
        if (edges !== exp_edges || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges valid=%b, want %0d", nm, edges, out_valid, exp_edges);
        end
        checks++;
        if ({out_sign, out_exp, out_frac, out_ovf, out_unf} !== {s, e, f, ovf, unf}) begin
            errors++;
            $display("FAIL %s result: got s=%b e=%h f=%h o=%b u=%b, want s=%b e=%h f=%h o=%b u=%b",
                     nm, out_sign, out_exp, out_frac, out_ovf, out_unf, s, e, f, ovf, unf);
        end
    endtask

    // With out_ready high, DONE lasts one edge and the block returns to IDLE.
    task automatic check_release(input string nm);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: valid=%b ready=%b busy=%b, want 0 1 0", nm, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, busy, out_sign, out_exp, out_frac, out_ovf, out_unf} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 23'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b s=%b e=%h f=%h o=%b u=%b, want 1 0 0 0 00 0 0 0",
                     in_ready, out_valid, busy, out_sign, out_exp, out_frac, out_ovf, out_unf);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_normalized();
        int n;
        send(1'b1, 8'h80, 25'h0800000);
        wait_done(n);
        check_res("normalized", n, 1, 1'b1, 8'h80, 23'h0, 1'b0, 1'b0);
        check_release("normalized");
    endtask

    task automatic test_shift();
        int n;
        int bad;
        bad = 0;
        send(1'b0, 8'h85, 25'h0040001);
        n = 0;
        while (!out_valid && n < 64) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL shift5 busy/ready during NORM: %0d bad cycles, want 0", bad);
        end
        check_res("shift5", n, 6, 1'b0, 8'h80, 23'h000020, 1'b0, 1'b0);
        check_release("shift5");
    endtask

    task automatic test_carry();
        int n;
        send(1'b0, 8'h7F, 25'h1800001);
        wait_done(n);
        check_res("carry", n, 1, 1'b0, 8'h80, 23'h400000, 1'b0, 1'b0);
        check_release("carry");
        send(1'b1, 8'hFE, 25'h1000000);
        wait_done(n);
        check_res("overflow", n, 1, 1'b1, 8'hFF, 23'h0, 1'b1, 1'b0);
        check_release("overflow");
        send(1'b0, 8'hFF, 25'h0812345);
        wait_done(n);
        check_res("bypass", n, 1, 1'b0, 8'hFF, 23'h012345, 1'b0, 1'b0);
        check_release("bypass");
    endtask

    task automatic test_zero_unf();
        int n;
        send(1'b1, 8'h40, 25'h0);
        wait_done(n);
        check_res("zero", n, 1, 1'b1, 8'h00, 23'h0, 1'b0, 1'b0);
        check_release("zero");
        send(1'b0, 8'h02, 25'h0000010);
        wait_done(n);
        check_res("flush_exp1", n, 2, 1'b0, 8'h00, 23'h0, 1'b0, 1'b1);
        check_release("flush_exp1");
        send(1'b1, 8'h00, 25'h0800001);
        wait_done(n);
        check_res("flush_exp0", n, 1, 1'b1, 8'h00, 23'h0, 1'b0, 1'b1);
        check_release("flush_exp0");
        // hidden bit at bit 0: maximum latency of FRAC_W+1 edges
        send(1'b0, 8'h40, 25'h0000001);
        wait_done(n);
        check_res("max_shift", n, 24, 1'b0, 8'h29, 23'h0, 1'b0, 1'b0);
        check_release("max_shift");
    endtask

    task automatic test_back_pressure();
        int n;
        int bad;
        bad = 0;
        @(negedge clk); out_ready = 1'b0;
        send(1'b0, 8'h81, 25'h0C00000);
        wait_done(n);
        check_res("bp_first", n, 1, 1'b0, 8'h81, 23'h400000, 1'b0, 1'b0);
        @(negedge clk);
        in_sign = 1'b1; in_exp = 8'h10; in_mant = 25'h0800000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_sign, out_exp, out_frac, out_ovf, out_unf} !== {1'b0, 8'h81, 23'h400000, 1'b0, 1'b0})
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_pressure hold: %0d unstable cycles, want 0", bad);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        check_release("back_pressure");
        send(1'b1, 8'h10, 25'h0800000);
        wait_done(n);
        check_res("bp_next", n, 1, 1'b1, 8'h10, 23'h0, 1'b0, 1'b0);
        check_release("bp_next");
    endtask

    task automatic test_reset_mid();
        int n;
        send(1'b0, 8'h85, 25'h0040001);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_sign, out_exp, out_frac, out_ovf, out_unf} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 23'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b s=%b e=%h f=%h o=%b u=%b, want 1 0 0 0 00 0 0 0",
                     in_ready, out_valid, busy, out_sign, out_exp, out_frac, out_ovf, out_unf);
        end
        @(negedge clk); rst = 1'b0;
        send(1'b1, 8'h85, 25'h0040001);
        wait_done(n);
        check_res("after_reset", n, 6, 1'b1, 8'h80, 23'h000020, 1'b0, 1'b0);
        check_release("after_reset");
    endtask

    initial begin
        test_reset();
        test_normalized();
        test_shift();
        test_carry();
        test_zero_unf();
        test_back_pressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
